// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU mode/op codes, flag bit positions and sequencer state encoding
package alu_pkg;
  localparam logic ALU_LOGIC = 1'b0;
  localparam logic ALU_ARITH = 1'b1;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_INC  = 4'd9;
  localparam logic [3:0] OP_DEC  = 4'd10;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_NOT  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_BUFA = 4'd5;
  localparam logic [3:0] OP_BUFB = 4'd6;
  localparam int ALU_CARRY_BIT = 0;
  localparam int ALU_ZERO_BIT  = 1;
  localparam int ALU_NEG_BIT   = 2;
  typedef enum logic [2:0] {ST_IDLE, ST_LO, ST_HI, ST_FIX, ST_DONE} seq_state_e;
  function automatic logic wide_legal(input logic mode, input logic [3:0] op);
    return mode ? (op == OP_ADD || op == OP_SUB) : (op >= OP_AND && op <= OP_BUFB);
  endfunction
endpackage

// File: rtl/alu.sv
// alu: combinational 8-bit ALU
//  mode in 1 (1 arith, 0 logic), op in 4, a/b in 8
//  result out 8, flags out 8 (carry/borrow, zero, negative; other bits 0)
//  undefined op codes give result 0
module alu
  import alu_pkg::*;
(
  input  logic       mode,
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic [7:0] flags
);
  logic [8:0] r9;
  always_comb begin
    r9 = '0;
    if (mode == ALU_ARITH)
      case (op)
        OP_ADD:  r9 = {1'b0, a} + {1'b0, b};
        OP_SUB:  r9 = {1'b0, a} - {1'b0, b};
        OP_INC:  r9 = {1'b0, a} + 9'd1;
        OP_DEC:  r9 = {1'b0, a} - 9'd1;
        default: r9 = '0;
      endcase
    else
      case (op)
        OP_AND:  r9 = {1'b0, a & b};
        OP_OR:   r9 = {1'b0, a | b};
        OP_NOT:  r9 = {1'b0, ~a};
        OP_XOR:  r9 = {1'b0, a ^ b};
        OP_BUFA: r9 = {1'b0, a};
        OP_BUFB: r9 = {1'b0, b};
        default: r9 = '0;
      endcase
    result = r9[7:0];
    flags = '0;
    flags[ALU_CARRY_BIT] = r9[8];
    flags[ALU_ZERO_BIT] = r9[7:0] == 8'd0;
    flags[ALU_NEG_BIT] = r9[7];
  end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: valid/ready sequencer around one alu, composing 16-bit ops from 8-bit passes
//  req_valid/req_ready/req_mode/req_op/req_wide/req_a/req_b : request channel
//  rsp_valid/rsp_ready/rsp_result/rsp_flags/rsp_err         : response channel
//  busy : sequencer not idle
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int CARRY_BIT = ALU_CARRY_BIT,
  parameter int ZERO_BIT  = ALU_ZERO_BIT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_mode,
  input  logic [3:0]  req_op,
  input  logic        req_wide,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [7:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy
);
  seq_state_e state, state_n;
  logic        cap_mode, cap_wide, lo_carry, hi_carry, act, to_done, wide_c;
  logic [3:0]  cap_op, alu_op;
  logic [15:0] cap_a, cap_b, wide_res;
  logic [7:0]  res_lo, res_hi, alu_a, alu_b, alu_result, alu_flags, wide_flags;
  logic        alu_mode;
  assign req_ready = state == ST_IDLE;
  assign busy      = state != ST_IDLE;
  assign rsp_valid = state == ST_DONE;
  assign act       = state == ST_LO || state == ST_HI;
  assign to_done   = state_n == ST_DONE && state != ST_DONE;
  // FIX pass propagates the low-byte carry/borrow into the high byte with inc/dec
  always_comb begin
    alu_mode = state == ST_FIX ? ALU_ARITH : act ? cap_mode : ALU_LOGIC;
    alu_op   = state == ST_FIX ? (cap_op == OP_ADD ? OP_INC : OP_DEC) : act ? cap_op : 4'd0;
    alu_a    = state == ST_LO ? cap_a[7:0] : state == ST_HI ? cap_a[15:8] : state == ST_FIX ? res_hi : 8'd0;
    alu_b    = state == ST_LO ? cap_b[7:0] : state == ST_HI ? cap_b[15:8] : 8'd0;
  end
  alu u_alu (
    .mode   (alu_mode),
    .op     (alu_op),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .flags  (alu_flags)
  );
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (req_valid) state_n = (req_wide && !wide_legal(req_mode, req_op)) ? ST_DONE : ST_LO;
      ST_LO:   state_n = cap_wide ? ST_HI : ST_DONE;
      ST_HI:   state_n = (cap_mode == ALU_ARITH && lo_carry) ? ST_FIX : ST_DONE;
      ST_FIX:  state_n = ST_DONE;
      ST_DONE: if (rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end
  // wide result/flags as seen in the final pass (HI or FIX)
  always_comb begin
    wide_res = {alu_result, res_lo};
    wide_c = state == ST_FIX ? (hi_carry | alu_flags[CARRY_BIT]) : (cap_mode == ALU_ARITH && alu_flags[CARRY_BIT]);
    wide_flags = alu_flags;
    wide_flags[ZERO_BIT] = wide_res == 16'd0;
    wide_flags[CARRY_BIT] = wide_c;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cap_mode   <= 1'b0;
      cap_op     <= '0;
      cap_wide   <= 1'b0;
      cap_a      <= '0;
      cap_b      <= '0;
      res_lo     <= '0;
      res_hi     <= '0;
      lo_carry   <= 1'b0;
      hi_carry   <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && req_valid) begin
        cap_mode <= req_mode;
        cap_op   <= req_op;
        cap_wide <= req_wide;
        cap_a    <= req_a;
        cap_b    <= req_b;
      end
      if (state == ST_LO) begin
        res_lo   <= alu_result;
        lo_carry <= alu_flags[CARRY_BIT];
      end
      if (state == ST_HI || state == ST_FIX) res_hi <= alu_result;
      if (state == ST_HI) hi_carry <= alu_flags[CARRY_BIT];
      // entering DONE straight from IDLE means an illegal wide request
      if (to_done) begin
        rsp_result <= state == ST_IDLE ? 16'd0 : cap_wide ? wide_res : {8'h00, alu_result};
        rsp_flags  <= state == ST_IDLE ? 8'd0 : cap_wide ? wide_flags : alu_flags;
        rsp_err    <= state == ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with an arithmetic reference model
module tb_alu_sequencer;
  import alu_pkg::*;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_mode = 1'b0, req_wide = 1'b0, rsp_ready = 1'b0;
  logic [3:0]  req_op = '0;
  logic [15:0] req_a = '0, req_b = '0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [15:0] rsp_result;
  logic [7:0]  rsp_flags;
  typedef struct {
    logic [15:0] res;
    logic [7:0]  flags;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t q[$];
  exp_t me;
  int cyc = 0, checks = 0, passed = 0, force_stall = 0;
  logic held = 1'b0, h_err;
  logic [15:0] h_res;
  logic [7:0]  h_flags;
  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .req_op(req_op), .req_wide(req_wide), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask
  // Reference: whole-word arithmetic on 8 or 16 bits; flags bit0 carry/borrow, bit1 zero, bit2 sign
  function automatic exp_t model(input logic mode, input logic [3:0] op, input logic wide,
                                 input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int w, mask, ua, ub, r, c;
    logic legal;
    w = wide ? 16 : 8;
    mask = (1 << w) - 1;
    ua = int'(a) & mask;
    ub = int'(b) & mask;
    r = 0;
    c = 0;
    legal = mode ? (op == 1 || op == 3) : (op >= 1 && op <= 6);
    e.acc = 0;
    if (wide && !legal) begin
      e.res = 16'd0; e.flags = 8'd0; e.err = 1'b1; e.lat = 1;
      return e;
    end
    if (mode)
      case (op)
        1: begin r = ua + ub; c = int'(r > mask); end
        3: begin r = ua - ub; c = int'(ua < ub); end
        9: begin r = ua + 1; c = int'(ua == mask); end
        10: begin r = ua - 1; c = int'(ua == 0); end
        default: ;
      endcase
    else
      case (op)
        1: r = ua & ub;
        2: r = ua | ub;
        3: r = ~ua;
        4: r = ua ^ ub;
        5: r = ua;
        6: r = ub;
        default: ;
      endcase
    r = r & mask;
    e.res = 16'(r);
    e.flags = 8'd0;
    e.flags[0] = c[0];
    e.flags[1] = r == 0;
    e.flags[2] = r[w-1];
    e.err = 1'b0;
    if (!wide) e.lat = 2;
    else if (mode && ((op == 1 && int'(a[7:0]) + int'(b[7:0]) > 255) || (op == 3 && a[7:0] < b[7:0]))) e.lat = 4;
    else e.lat = 3;
    return e;
  endfunction
  task automatic issue(input logic mode, input logic [3:0] op, input logic wide,
                       input logic [15:0] a, input logic [15:0] b, input bit push);
    exp_t e;
    int t;
    t = 0;
    req_mode = mode; req_op = op; req_wide = wide; req_a = a; req_b = b; req_valid = 1'b1;
    while (!req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      checks++;
      $display("FAIL req_ready_timeout: got 0 expected 1 within 100 cycles");
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (push) begin
      e = model(mode, op, wide, a, b);
      e.acc = cyc;
      q.push_back(e);
    end
  endtask
  task automatic drain(input int limit);
    int t;
    t = 0;
    while ((q.size() != 0 || rsp_valid) && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0 || rsp_valid) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else if (rsp_valid) begin
        chk("req_ready_in_done", req_ready, 0);
        chk("busy_in_done", busy, 1);
        if (held) begin
          chk("stable_result", rsp_result, h_res);
          chk("stable_flags", rsp_flags, h_flags);
          chk("stable_err", rsp_err, h_err);
        end else if (q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_rsp: got result %0h expected no response", rsp_result);
        end else begin
          me = q.pop_front();
          chk("result", rsp_result, me.res);
          chk("flags", rsp_flags, me.flags);
          chk("err", rsp_err, me.err);
          chk("latency", cyc - me.acc + 1, me.lat);
          h_res = rsp_result; h_flags = rsp_flags; h_err = rsp_err;
        end
        rsp_ready = force_stall > 0 ? 1'b0 : ($urandom_range(0, 2) != 0);
        if (force_stall > 0) force_stall--;
        held = !rsp_ready;
      end else begin
        rsp_ready = 1'($urandom_range(0, 1));
        held = 1'b0;
      end
    end
  end
  initial begin
    logic m, w;
    logic [3:0] op;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    issue(ALU_ARITH, OP_ADD, 1'b0, 16'h0005, 16'h0003, 1'b1);
    issue(ALU_ARITH, OP_ADD, 1'b1, 16'h00FF, 16'h0001, 1'b1);
    issue(ALU_ARITH, OP_ADD, 1'b1, 16'hFFFF, 16'h0001, 1'b1);
    issue(ALU_LOGIC, OP_AND, 1'b1, 16'h0FF0, 16'h00FF, 1'b1);
    issue(ALU_ARITH, OP_SUB, 1'b1, 16'h0100, 16'h0001, 1'b1);
    issue(ALU_ARITH, OP_SUB, 1'b1, 16'h0000, 16'h0001, 1'b1);
    issue(ALU_ARITH, 4'd5, 1'b1, 16'h1234, 16'h5678, 1'b1);
    issue(ALU_ARITH, OP_SUB, 1'b0, 16'h0003, 16'h0005, 1'b1);
    drain(100);
    force_stall = 5;
    issue(ALU_LOGIC, OP_XOR, 1'b1, 16'hA5A5, 16'h0FF0, 1'b1);
    drain(100);
    issue(ALU_ARITH, OP_ADD, 1'b1, 16'h12FF, 16'h0101, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_result", rsp_result, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(ALU_ARITH, OP_ADD, 1'b1, 16'h0180, 16'h0080, 1'b1);
    for (int i = 0; i < 150; i++) begin
      m = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 3) == 0 ? 4'($urandom_range(0, 15)) :
           m ? ($urandom_range(0, 1) != 0 ? OP_ADD : OP_SUB) : 4'($urandom_range(1, 6));
      issue(m, op, w, 16'($urandom), 16'($urandom), 1'b1);
    end
    drain(500);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
